sat_add_simd_pipe: RTL

- Parametrised, pipelined, lane-partitioned (SIMD) saturating adder/subtractor for the datapath.
- Computes LANES independent LANE_W-bit operations per transaction (e.g. packed PADDSB-style instructions).
- Supports signed or unsigned, add or subtract, saturate or wrap.
- Two-stage elastic pipeline with valid/ready handshake on both sides; sits between the operand-read stage and writeback.

---
 rtl/sat_add_simd_pipe.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sat_add_simd_pipe.sv
// Two-stage elastic SIMD adder/subtractor: LANES independent LANE_W-bit lanes, signed or
// unsigned, saturate or wrap. Define SAT_ADD_SIMD_STICKY_OVFL_EN to build the sticky overflow register.
module sat_add_simd_pipe #(
    parameter int  LANE_W = 4,
    parameter int  LANES  = 4,
    localparam int W      = LANES * LANE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_sub,
    input  logic             in_uns,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic [LANES-1:0] out_ovfl,
    output logic [LANES-1:0] sticky_ovfl,
    input  logic             sticky_clr
);

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         uns;
        logic         sat;
    } op_t;

    op_t              s1_q, s1_d;
    logic             s1_valid_q, s1_valid_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_sum_q, out_sum_d;
    logic [LANES-1:0] out_ovfl_q, out_ovfl_d;

    logic             s1_en;
    logic             s2_en;
    logic [W-1:0]     lane_sum;
    logic [LANES-1:0] lane_ovfl;

    // Each stage may advance when it is empty or its occupant is leaving this cycle.
    always_comb begin : handshake
        s2_en = ~out_valid_q | out_ready;
        s1_en = ~s1_valid_q | s2_en;
    end

    assign in_ready = s1_en;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin : s1_next
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (s1_en) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d.a   = in_a;
                s1_d.b   = in_b;
                s1_d.sub = in_sub;
                s1_d.uns = in_uns;
                s1_d.sat = in_sat;
            end
        end
    end

    // Per-lane add of a + (sub ? ~b : b) + sub, one extra bit to expose the carry/borrow.
    always_comb begin : lane_math
        logic [LANE_W-1:0] a_l;
        logic [LANE_W-1:0] b_eff;
        logic [LANE_W-1:0] r;
        logic [LANE_W-1:0] sat_val;
        logic [LANE_W:0]   ext;
        logic              ovfl;

        lane_sum  = '0;
        lane_ovfl = '0;
        a_l       = '0;
        b_eff     = '0;
        r         = '0;
        sat_val   = '0;
        ext       = '0;
        ovfl      = 1'b0;

        for (int i = 0; i < LANES; i++) begin
            a_l   = s1_q.a[i*LANE_W +: LANE_W];
            b_eff = s1_q.sub ? ~s1_q.b[i*LANE_W +: LANE_W] : s1_q.b[i*LANE_W +: LANE_W];
            ext   = {1'b0, a_l} + {1'b0, b_eff} + {{LANE_W{1'b0}}, s1_q.sub};
            r     = ext[LANE_W-1:0];

            if (s1_q.uns) begin
                // Add overflows on carry out; subtract underflows when no carry (a borrow).
                ovfl    = ext[LANE_W] ^ s1_q.sub;
                sat_val = {LANE_W{~s1_q.sub}};
            end else begin
                ovfl    = (a_l[LANE_W-1] == b_eff[LANE_W-1]) && (r[LANE_W-1] != a_l[LANE_W-1]);
                // Negative operands clamp to min (1000..), positive to max (0111..).
                sat_val = {a_l[LANE_W-1], {(LANE_W-1){~a_l[LANE_W-1]}}};
            end

            lane_sum[i*LANE_W +: LANE_W] = (ovfl && s1_q.sat) ? sat_val : r;
            lane_ovfl[i]                 = ovfl;
        end
    end

    // A bubble advancing into S2 clears out_valid but leaves the result registers untouched.
    always_comb begin : s2_next
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ovfl_d  = out_ovfl_q;
        if (s2_en) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_sum_d  = lane_sum;
                out_ovfl_d = lane_ovfl;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovfl_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovfl_q  <= out_ovfl_d;
        end
    end

    // NOTE: the S1 operand payload is qualified by s1_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        s1_q <= s1_d;
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovfl  = out_ovfl_q;

`ifdef SAT_ADD_SIMD_STICKY_OVFL_EN
    logic [LANES-1:0] sticky_q, sticky_d;

    // Clear wins over a same-cycle set from an outgoing overflow.
    always_comb begin : sticky_next
        sticky_d = sticky_q;
        if (sticky_clr) begin
            sticky_d = '0;
        end else if (out_valid_q && out_ready) begin
            sticky_d = sticky_q | out_ovfl_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_ovfl = sticky_q;
`else
    logic unused_sticky_clr;

    assign unused_sticky_clr = sticky_clr;
    assign sticky_ovfl       = '0;
`endif

endmodule
